// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the packed saturating subtract path
package alu_pkg;
  localparam int LANE_W = 4;
  localparam logic [3:0] SAT_POS_4 = 4'h7;
  localparam logic [3:0] SAT_NEG_4 = 4'h8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} psub_state_t;
endpackage

// File: rtl/sat_sub_lane.sv
// sat_sub_lane: one signed lane a - b with optional saturation and overflow flag
module sat_sub_lane
  import alu_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sat_en,
  output logic [LANE_W-1:0] d,
  output logic              ovf
);
  logic [LANE_W-1:0] diff;
  always_comb begin
    diff = a + ~b + LANE_W'(1);
    ovf = (a[LANE_W-1] != b[LANE_W-1]) & (diff[LANE_W-1] != a[LANE_W-1]);
    d = (sat_en & ovf) ? (a[LANE_W-1] ? SAT_NEG_4 : SAT_POS_4) : diff;
  end
endmodule

// File: rtl/psub_serial_sat.sv
// psub_serial_sat: packed saturating subtract, one lane per cycle through a shared lane unit
module psub_serial_sat
  import alu_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W*NUM_LANES-1:0] A,
  input  logic [LANE_W*NUM_LANES-1:0] B,
  input  logic                        sat_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W*NUM_LANES-1:0] D,
  output logic                        V,
  output logic                        Z
);
  localparam int DW = LANE_W * NUM_LANES;
  localparam int IW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  psub_state_t state, state_nx;
  logic [DW-1:0] a_q, b_q, d_q;
  logic sat_q, v_q, ovf_l, last, accept;
  logic [IW-1:0] idx;
  logic [LANE_W-1:0] d_l;
  sat_sub_lane u_lane (
    .a(a_q[idx*LANE_W +: LANE_W]),
    .b(b_q[idx*LANE_W +: LANE_W]),
    .sat_en(sat_q),
    .d(d_l),
    .ovf(ovf_l)
  );
  always_comb begin
    last = idx == IW'(NUM_LANES - 1);
    accept = (state == IDLE) & in_valid;
    state_nx = accept ? RUN
             : (state == RUN && last) ? DONE
             : (state == DONE && out_ready) ? IDLE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sat_q <= 1'b0;
      d_q <= '0;
      v_q <= 1'b0;
      idx <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= A;
        b_q <= B;
        sat_q <= sat_en;
        d_q <= '0;
        v_q <= 1'b0;
        idx <= '0;
      end else if (state == RUN) begin
        d_q[idx*LANE_W +: LANE_W] <= d_l;
        v_q <= v_q | ovf_l;
        if (!last) idx <= idx + IW'(1);
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign D = d_q;
  assign V = v_q;
  assign Z = d_q == '0;
endmodule

// File: tb/tb_psub_serial_sat.sv
// tb_psub_serial_sat: random and directed checks against a signed-integer lane model
module tb_psub_serial_sat;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, sat_en = 1'b0, out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic in_ready, out_valid, V, Z;
  logic [15:0] D;
  int n_checks = 0, n_fail = 0;
  int m_run = 0;
  logic m_done = 1'b0, m_v = 1'b0;
  logic [15:0] m_d = '0;

  psub_serial_sat dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] d, output logic v);
    d = '0;
    v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int x, y, r;
      x = $signed(a[4*i +: 4]);
      y = $signed(b[4*i +: 4]);
      r = x - y;
      if (r > 7 || r < -8) begin
        v = 1'b1;
        if (s) r = (r > 7) ? 7 : -8;
      end
      d[4*i +: 4] = r[3:0];
    end
  endfunction

  // Transaction-level model: accept when idle, result due four edges later, held until taken
  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_run > 0) begin
      m_run--;
      m_done = m_run == 0;
    end else if (in_valid) begin
      model(A, B, sat_en, m_d, m_v);
      m_run = 4;
    end
    #1;
    chk("in_ready", in_ready, !m_done && m_run == 0);
    chk("out_valid", out_valid, m_done);
    if (m_done) begin
      chk("D", D, m_d);
      chk("V", V, m_v);
      chk("Z", Z, m_d == 16'h0);
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold,
                        output logic [15:0] d, output logic v, output logic z, output int lat);
    @(negedge clk);
    A = a; B = b; sat_en = s; in_valid = 1'b1; out_ready = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); sat_en = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!out_valid) out_ready = 1'($urandom);
    end
    out_ready = 1'b0;
    if (!out_valid) chk("out_valid timeout", 0, 1);
    d = D; v = V; z = Z;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
      chk("hold D", D, d);
      chk("hold V", V, v);
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready after take", in_ready, 1);
  endtask

  logic [15:0] d, ed;
  logic v, z, ev;
  int lat;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset D", D, 0);
    chk("reset V", V, 0);
    chk("reset out_valid", out_valid, 0);
    rst_n = 1'b1;
    model(16'h1234, 16'h1111, 1'b1, ed, ev); chk("model t1", {ev, ed}, {1'b0, 16'h0123});
    model(16'h7080, 16'h1010, 1'b1, ed, ev); chk("model t2s", {ev, ed}, {1'b1, 16'h6080});
    model(16'h7080, 16'h1010, 1'b0, ed, ev); chk("model t2w", {ev, ed}, {1'b1, 16'h6070});
    model(16'h0700, 16'h0800, 1'b1, ed, ev); chk("model t3", {ev, ed}, {1'b1, 16'h0700});
    model(16'h0700, 16'h0800, 1'b0, ed, ev); chk("model t3w", {ev, ed}, {1'b1, 16'h0F00});

    run_op(16'h1234, 16'h1111, 1'b1, 0, d, v, z, lat);
    chk("t1 D", d, 16'h0123); chk("t1 V", v, 0); chk("t1 Z", z, 0); chk("t1 latency", lat, 4);
    run_op(16'h7080, 16'h1010, 1'b1, 0, d, v, z, lat);
    chk("t2 sat D", d, 16'h6080); chk("t2 sat V", v, 1);
    run_op(16'h7080, 16'h1010, 1'b0, 0, d, v, z, lat);
    chk("t2 wrap D", d, 16'h6070); chk("t2 wrap V", v, 1);
    run_op(16'h0700, 16'h0800, 1'b1, 0, d, v, z, lat);
    chk("t3 D", d, 16'h0700); chk("t3 V", v, 1);
    run_op(16'hABCD, 16'hABCD, 1'($urandom), 0, d, v, z, lat);
    chk("t4 D", d, 16'h0000); chk("t4 Z", z, 1); chk("t4 V", v, 0);
    run_op(16'h7080, 16'h1010, 1'b0, 3, d, v, z, lat);
    chk("t5 D", d, 16'h6070);
    run_op(16'h1234, 16'h1111, 1'b1, 0, d, v, z, lat);
    chk("t5 next D", d, 16'h0123);

    @(negedge clk);
    A = 16'h7777; B = 16'h8888; sat_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort D", D, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1);
    chk("release out_valid", out_valid, 0);
    run_op(16'h1234, 16'h1111, 1'b1, 0, d, v, z, lat);
    chk("t6 D", d, 16'h0123);

    for (int k = 0; k < 60; k++) begin
      logic [15:0] a, b;
      logic s;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      if (k % 7 == 0) b = a;
      run_op(a, b, s, int'($urandom_range(0, 3)), d, v, z, lat);
      model(a, b, s, ed, ev);
      chk("rand D", d, ed);
      chk("rand V", v, ev);
      chk("rand Z", z, ed == 16'h0);
      chk("rand latency", lat, 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
